scan_sequencer: RTL
===================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000, number of clock cycles en is held high per selected line (legal range 1..65535).
REQ-002 Parameter BLANK_CYCLES, default 4, number of clock cycles en is held low between lines (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  level; sampled in IDLE only, begins scanning.
REQ-006 stop  input  1  level; sampled in every state, aborts scanning.
REQ-007 mask  input  8  line-enable mask, bit i set = line i scanned; sampled at every line advance.
REQ-008 sel  output  3  registered line index, driven directly to the downstream 3-to-8 decoder select input.
REQ-009 en  output  1  registered decoder enable; high only while a line is being driven.
REQ-010 busy  output  1  registered; high in any state other than IDLE.
REQ-011 frame_done  output  1  registered one-cycle pulse on wrap-around of the scan order.

Function
REQ-012 FSM states IDLE, DWELL, BLANK; all outputs are registered, with no combinational path from inputs to outputs.
REQ-013 IDLE: en=0, sel=0, busy=0; start=1 and stop=0 at an edge -> DWELL, sel = lowest set mask bit, en=1 and busy=1 visible after that edge.
REQ-014 start in IDLE with mask==0 -> BLANK, en=0, busy=1, sel=0.
REQ-015 DWELL: en=1 for exactly DWELL_CYCLES cycles, then -> BLANK with en=0; sel unchanged on that edge.
REQ-016 BLANK: en=0 for exactly BLANK_CYCLES cycles; on the first BLANK edge sel loads the next index; on the last BLANK edge the FSM -> DWELL, en=1.
REQ-017 Next index: circular search upward from sel+1 modulo 8, returning the first set mask bit; a single set bit returns the same index.
REQ-018 Wrap-around: frame_done=1 for one cycle, coincident with the sel update, when the next index <= the current index.
REQ-019 mask==0 at an advance: remain in BLANK with en=0, re-evaluate every cycle, enter DWELL on the first cycle mask!=0, with no frame_done.
REQ-020 stop=1 in DWELL or BLANK -> IDLE on the next edge: en=0, sel=0, busy=0, frame_done=0; any partial dwell is discarded.
REQ-021 start and stop both high in IDLE: stop wins, remain IDLE; start is ignored in DWELL and BLANK.
REQ-022 mask changes mid-dwell do not affect the current line; they take effect at the next advance only.
REQ-023 The dwell and blank counters are sized by clog2 of their parameter, and the counts are exact, with no off-by-one.

Reset
REQ-024 rst=1 forces IDLE asynchronously: sel=0, en=0, busy=0, frame_done=0, counters=0.
REQ-025 Reset mid-scan drops en within the reset assertion, not at the next edge; after release the block waits for a fresh start.

Configuration
REQ-026 Macro SCAN_SKIP_MASK_EN defined: mask is honored per REQ-013..REQ-022.
REQ-027 Macro SCAN_SKIP_MASK_EN undefined: the mask port remains but is ignored, treated as 8'hFF; sel steps 0..7 sequentially, and REQ-014/REQ-019 are unreachable.

Structure
REQ-028 Package scan_pkg holds the state enum (IDLE/DWELL/BLANK), NUM_LINES=8, and IDX_W=3.
REQ-029 Sub-module scan_next_idx (combinational: mask, cur index -> next index, wrap flag) implements REQ-017/REQ-018 and is instantiated once.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, SCAN_SKIP_MASK_EN defined unless noted)
REQ-030 mask=8'hFF, pulse start -> sel 0,1,...,7,0; each line has en high 4 cycles then low 2; frame_done single pulse at the 7->0 update; period 48 cycles.
REQ-031 mask=8'b1000_0100, start -> sel alternates 2,7,2; frame_done on each 7->2 update only.
REQ-032 mask=0, start -> busy=1, en=0, sel=0 indefinitely; set mask=8'h10 -> en high within 1 cycle, with sel=4.
REQ-033 stop asserted in the 2nd DWELL cycle of line 3 -> next edge en=0, sel=0, busy=0; start+stop together in IDLE -> stays IDLE.
REQ-034 rst asserted between edges mid-DWELL -> en=0 immediately; no activity after release until start.
REQ-035 Macro undefined, mask=8'h01, start -> all 8 lines scanned 0..7, identical to REQ-030.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and sizes for the scan sequencer and its next-line search.
package scan_pkg;
   localparam int NUM_LINES = 8;
   localparam int IDX_W     = 3;

   typedef enum logic [1:0] {
      IDLE,
      DWELL,
      BLANK
   } state_t;
endpackage

// File: rtl/scan_next_idx.sv
// Combinational circular search from cur_idx+1 for the next enabled line; wrap when it does not move upward.
module scan_next_idx
   import scan_pkg::*;
(
   input  logic [NUM_LINES-1:0] mask,
   input  logic [IDX_W-1:0]     cur_idx,
   output logic [IDX_W-1:0]     next_idx,
   output logic                 wrap
);
   logic [IDX_W-1:0] cand;

   // Scan the farthest candidate first so the nearest set bit is the one left standing.
   always_comb begin
      next_idx = cur_idx;
      cand     = '0;
      for (int k = NUM_LINES; k >= 1; k--) begin
         cand = cur_idx + IDX_W'(k);
         if (mask[cand]) next_idx = cand;
      end
   end

   assign wrap = (next_idx <= cur_idx);
endmodule

// File: rtl/scan_sequencer.sv
// Line scanner for a 3-to-8 decoder: en high DWELL_CYCLES per line, low BLANK_CYCLES between; all outputs registered.
// No backpressure; define SCAN_SKIP_MASK_EN to honour mask, otherwise lines 0..7 are scanned in order.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [NUM_LINES-1:0] mask,
   output logic [IDX_W-1:0]     sel,
   output logic                 en,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BW_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [BW_W-1:0] BL_LAST = BW_W'(BLANK_CYCLES - 1);

   state_t               state, state_nxt;
   logic [DW_W-1:0]      dwell_cnt, dwell_cnt_nxt;
   logic [BW_W-1:0]      blank_cnt, blank_cnt_nxt;
   logic                 hold, hold_nxt;
   logic                 fresh, fresh_nxt;
   logic [IDX_W-1:0]     sel_nxt, search_from, next_idx;
   logic                 en_nxt, busy_nxt, frame_done_nxt, wrap, mask_any;
   logic [NUM_LINES-1:0] eff_mask;

`ifdef SCAN_SKIP_MASK_EN
   assign eff_mask = mask;
`else
   logic unused_mask;
   assign unused_mask = ^mask;
   assign eff_mask    = '1;
`endif

   assign mask_any = |eff_mask;
   // Starting from the last line makes the circular search return the lowest enabled line.
   assign search_from = (state == IDLE || fresh) ? IDX_W'(NUM_LINES - 1) : sel;

   scan_next_idx u_next_idx (
      .mask     (eff_mask),
      .cur_idx  (search_from),
      .next_idx (next_idx),
      .wrap     (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dwell_cnt  <= '0;
         blank_cnt  <= '0;
         hold       <= 1'b0;
         fresh      <= 1'b0;
         sel        <= '0;
         en         <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         dwell_cnt  <= dwell_cnt_nxt;
         blank_cnt  <= blank_cnt_nxt;
         hold       <= hold_nxt;
         fresh      <= fresh_nxt;
         sel        <= sel_nxt;
         en         <= en_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      dwell_cnt_nxt  = dwell_cnt;
      blank_cnt_nxt  = blank_cnt;
      hold_nxt       = hold;
      fresh_nxt      = fresh;
      sel_nxt        = sel;
      en_nxt         = en;
      busy_nxt       = busy;
      frame_done_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (start && !stop) begin
               busy_nxt      = 1'b1;
               dwell_cnt_nxt = '0;
               blank_cnt_nxt = '0;
               if (mask_any) begin
                  state_nxt = DWELL;
                  sel_nxt   = next_idx;
                  en_nxt    = 1'b1;
               end else begin
                  state_nxt = BLANK;
                  sel_nxt   = '0;
                  en_nxt    = 1'b0;
                  hold_nxt  = 1'b1;
                  fresh_nxt = 1'b1;
               end
            end
         end
         DWELL: begin
            if (dwell_cnt == DW_LAST) begin
               state_nxt     = BLANK;
               en_nxt        = 1'b0;
               dwell_cnt_nxt = '0;
               blank_cnt_nxt = '0;
            end else begin
               dwell_cnt_nxt = dwell_cnt + DW_W'(1);
            end
         end
         BLANK: begin
            if (hold) begin
               if (mask_any) begin
                  state_nxt     = DWELL;
                  en_nxt        = 1'b1;
                  sel_nxt       = next_idx;
                  hold_nxt      = 1'b0;
                  fresh_nxt     = 1'b0;
                  blank_cnt_nxt = '0;
               end
            end else if (blank_cnt == '0 && !mask_any) begin
               hold_nxt = 1'b1;
            end else begin
               if (blank_cnt == '0) begin
                  sel_nxt        = next_idx;
                  frame_done_nxt = wrap;
               end
               if (blank_cnt == BL_LAST) begin
                  state_nxt     = DWELL;
                  en_nxt        = 1'b1;
                  blank_cnt_nxt = '0;
               end else begin
                  blank_cnt_nxt = blank_cnt + BW_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (stop && state != IDLE) begin
         state_nxt      = IDLE;
         dwell_cnt_nxt  = '0;
         blank_cnt_nxt  = '0;
         hold_nxt       = 1'b0;
         fresh_nxt      = 1'b0;
         sel_nxt        = '0;
         en_nxt         = 1'b0;
         busy_nxt       = 1'b0;
         frame_done_nxt = 1'b0;
      end
   end
endmodule
